rv32_ctrl_fsm: RTL

- Multi-cycle control unit for the RV32I core; issues work to the combinational ALU.
- Fetches and latches an instruction, decodes it into the 12-bit one-hot ALUop and datapath selects, and sequences memory handshakes and register write-back.
- Owns the PC and computes branch and jump redirects from the ALU Result/Zero fed back to it.

---
 rtl/rv32_ctrl_fsm.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32_ctrl_fsm.sv
// Multi-cycle RV32I control unit: fetch/decode/execute sequencing, one-hot ALUop
// generation, memory handshakes, write-back control and PC/branch redirect.
`timescale 1ns/1ps
module rv32_ctrl_fsm #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        Inst_Req_Valid,
    input  logic        Inst_Req_Ready,
    input  logic [31:0] Instruction,
    input  logic        Inst_Valid,
    output logic        Inst_Ready,
    output logic [31:0] PC,
    output logic [11:0] ALUop,
    output logic        alu_a_pc,
    output logic        alu_b_imm,
    output logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic        Mem_Req_Ready,
    input  logic        Read_data_Valid,
    output logic        Read_data_Ready,
    output logic        RegWrite,
    output logic [1:0]  wb_sel,
    output logic [4:0]  rd
);

    typedef enum logic [8:0] {
        S_INIT = 9'b0_0000_0001,
        S_IF   = 9'b0_0000_0010,
        S_IW   = 9'b0_0000_0100,
        S_ID   = 9'b0_0000_1000,
        S_EX   = 9'b0_0001_0000,
        S_ST   = 9'b0_0010_0000,
        S_LD   = 9'b0_0100_0000,
        S_RDW  = 9'b0_1000_0000,
        S_WB   = 9'b1_0000_0000
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ir_q;
    logic [31:0] imm_q;
    logic [11:0] aluop_q;
    logic        a_pc_q;
    logic        b_imm_q;
    logic        regwrite_q;
    logic [1:0]  wb_sel_q;

    logic        dec_ok_s;
    logic [11:0] dec_aluop_s;
    logic        dec_a_pc_s;
    logic        dec_b_imm_s;
    logic [31:0] dec_imm_s;
    logic [1:0]  dec_wb_sel_s;
    logic        dec_load_s;
    logic        dec_store_s;
    logic        dec_branch_s;
    logic        dec_jal_s;
    logic        dec_jalr_s;
    logic        br_taken_s;
    logic        alu_lsb_unused_s;

    // funct3 -> ALUop; alt selects sub/sra
    function automatic logic [11:0] alu_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_f3 = alt ? 12'h002 : 12'h001;
            3'b001:  alu_f3 = 12'h100;
            3'b010:  alu_f3 = 12'h040;
            3'b011:  alu_f3 = 12'h080;
            3'b100:  alu_f3 = 12'h020;
            3'b101:  alu_f3 = alt ? 12'h400 : 12'h200;
            3'b110:  alu_f3 = 12'h008;
            3'b111:  alu_f3 = 12'h004;
            default: alu_f3 = 12'h001;
        endcase
    endfunction

    // Instruction decode from the latched IR
    always_comb begin
        dec_ok_s     = 1'b0;
        dec_aluop_s  = 12'h000;
        dec_a_pc_s   = 1'b0;
        dec_b_imm_s  = 1'b0;
        dec_imm_s    = 32'h0000_0000;
        dec_wb_sel_s = 2'd0;
        dec_load_s   = 1'b0;
        dec_store_s  = 1'b0;
        dec_branch_s = 1'b0;
        dec_jal_s    = 1'b0;
        dec_jalr_s   = 1'b0;
        case (ir_q[6:0])
            7'b0110011: begin
                dec_ok_s    = 1'b1;
                dec_aluop_s = alu_f3(ir_q[14:12], ir_q[30]);
            end
            7'b0010011: begin
                dec_ok_s    = 1'b1;
                dec_b_imm_s = 1'b1;
                dec_aluop_s = alu_f3(ir_q[14:12], ir_q[30] & (ir_q[14:12] == 3'b101));
                // shift-immediates carry funct7 in imm[11:5]; only shamt goes to the ALU
                if (ir_q[13:12] == 2'b01) begin
                    dec_imm_s = {27'd0, ir_q[24:20]};
                end else begin
                    dec_imm_s = {{20{ir_q[31]}}, ir_q[31:20]};
                end
            end
            7'b0110111: begin
                dec_ok_s    = 1'b1;
                dec_aluop_s = 12'h800;
                dec_b_imm_s = 1'b1;
                dec_imm_s   = {ir_q[31:12], 12'd0};
            end
            7'b0010111: begin
                dec_ok_s    = 1'b1;
                dec_aluop_s = 12'h010;
                dec_a_pc_s  = 1'b1;
                dec_b_imm_s = 1'b1;
                dec_imm_s   = {ir_q[31:12], 12'd0};
            end
            7'b0000011: begin
                dec_ok_s     = 1'b1;
                dec_load_s   = 1'b1;
                dec_aluop_s  = 12'h001;
                dec_b_imm_s  = 1'b1;
                dec_wb_sel_s = 2'd1;
                dec_imm_s    = {{20{ir_q[31]}}, ir_q[31:20]};
            end
            7'b0100011: begin
                dec_ok_s    = 1'b1;
                dec_store_s = 1'b1;
                dec_aluop_s = 12'h001;
                dec_b_imm_s = 1'b1;
                dec_imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            end
            7'b1100011: begin
                if (ir_q[14:13] != 2'b01) begin
                    dec_ok_s     = 1'b1;
                    dec_branch_s = 1'b1;
                    dec_aluop_s  = ir_q[14] ? (ir_q[13] ? 12'h080 : 12'h040) : 12'h002;
                    dec_imm_s    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
                end else begin
                    dec_ok_s = 1'b0;
                end
            end
            7'b1101111: begin
                dec_ok_s     = 1'b1;
                dec_jal_s    = 1'b1;
                dec_aluop_s  = 12'h001;
                dec_a_pc_s   = 1'b1;
                dec_b_imm_s  = 1'b1;
                dec_wb_sel_s = 2'd2;
                dec_imm_s    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            end
            7'b1100111: begin
                dec_ok_s     = 1'b1;
                dec_jalr_s   = 1'b1;
                dec_aluop_s  = 12'h001;
                dec_b_imm_s  = 1'b1;
                dec_wb_sel_s = 2'd2;
                dec_imm_s    = {{20{ir_q[31]}}, ir_q[31:20]};
            end
            default: begin
                dec_ok_s = 1'b0;
            end
        endcase
    end

    // beq/bge/bgeu take on zero, the others on non-zero
    assign br_taken_s       = alu_zero ^ (ir_q[12] ^ ir_q[14]);
    assign alu_lsb_unused_s = alu_result[0];

    // Next PC at the end of EX
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (dec_jalr_s) begin
            pc_d = {alu_result[31:1], 1'b0};
        end else if (dec_jal_s || (dec_branch_s && br_taken_s)) begin
            pc_d = pc_q + imm_q;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Control FSM with registered datapath controls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_INIT;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0000_0000;
            imm_q      <= 32'h0000_0000;
            aluop_q    <= 12'h000;
            a_pc_q     <= 1'b0;
            b_imm_q    <= 1'b0;
            wb_sel_q   <= 2'd0;
            regwrite_q <= 1'b0;
        end else begin
            aluop_q    <= 12'h000;
            regwrite_q <= 1'b0;
            case (state_q)
                S_INIT: state_q <= S_IF;
                S_IF: begin
                    if (Inst_Req_Ready) state_q <= S_IW;
                end
                S_IW: begin
                    if (Inst_Valid) begin
                        ir_q    <= Instruction;
                        state_q <= S_ID;
                    end
                end
                S_ID: begin
                    if (dec_ok_s) begin
                        state_q  <= S_EX;
                        aluop_q  <= dec_aluop_s;
                        a_pc_q   <= dec_a_pc_s;
                        b_imm_q  <= dec_b_imm_s;
                        imm_q    <= dec_imm_s;
                        wb_sel_q <= dec_wb_sel_s;
                    end else begin
                        state_q <= S_IF;
                        pc_q    <= pc_q + 32'd4;
                    end
                end
                S_EX: begin
                    pc_q <= pc_d;
                    if (dec_load_s) begin
                        state_q <= S_LD;
                    end else if (dec_store_s) begin
                        state_q <= S_ST;
                    end else if (dec_branch_s) begin
                        state_q <= S_IF;
                    end else begin
                        state_q    <= S_WB;
                        regwrite_q <= (ir_q[11:7] != 5'd0);
                    end
                end
                S_ST: begin
                    if (Mem_Req_Ready) state_q <= S_IF;
                end
                S_LD: begin
                    if (Mem_Req_Ready) state_q <= S_RDW;
                end
                S_RDW: begin
                    if (Read_data_Valid) begin
                        state_q    <= S_WB;
                        regwrite_q <= (ir_q[11:7] != 5'd0);
                    end
                end
                S_WB:    state_q <= S_IF;
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign Inst_Req_Valid  = (state_q == S_IF);
    assign Inst_Ready      = (state_q == S_IW);
    assign MemWrite        = (state_q == S_ST);
    assign MemRead         = (state_q == S_LD);
    assign Read_data_Ready = (state_q == S_RDW);
    assign PC              = pc_q;
    assign ALUop           = aluop_q;
    assign alu_a_pc        = a_pc_q;
    assign alu_b_imm       = b_imm_q;
    assign imm             = imm_q;
    assign RegWrite        = regwrite_q;
    assign wb_sel          = wb_sel_q;
    assign rd              = ir_q[11:7];

endmodule
